// File: rtl/solver_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : solver_dispatch_if
// Brief    : Job, solver-configuration and result signals of solver_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
interface solver_dispatch_if #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int ITER_BITS       = 16
);
   logic                       job_valid;
   logic                       job_ready;
   logic [LIMB_INDEX_BITS-1:0] job_num_limbs;
   logic [ITER_BITS-1:0]       job_iter_lim;
   logic                       wr_num_limbs_en;
   logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
   logic                       wr_iter_lim_en;
   logic [ITER_BITS-1:0]       iter_lim_data;
   logic                       start;
   logic                       solver_done;
   logic                       solver_diverged;
   logic [ITER_BITS-1:0]       solver_iters;
   logic                       result_valid;
   logic                       result_ready;
   logic [ITER_BITS-1:0]       result_iters;
   logic                       result_diverged;
   logic                       result_timeout;
   logic                       result_error;
   logic                       busy;

   // master is the dispatcher; slave is the host/solver side
   modport master (
      input  job_valid, job_num_limbs, job_iter_lim,
      input  solver_done, solver_diverged, solver_iters, result_ready,
      output job_ready, wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
      output start, result_valid, result_iters, result_diverged, result_timeout,
      output result_error, busy
   );

   modport slave (
      output job_valid, job_num_limbs, job_iter_lim,
      output solver_done, solver_diverged, solver_iters, result_ready,
      input  job_ready, wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
      input  start, result_valid, result_iters, result_diverged, result_timeout,
      input  result_error, busy
   );
endinterface
`default_nettype wire

// File: rtl/solver_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : solver_dispatch
// Brief    : Host-side job driver for the solver: conditional register writes,
//            start pulse, watchdog-bounded wait and result return.
// Revision : 1.0 - initial release
// ============================================================================
module solver_dispatch #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int ITER_BITS       = 16,
   parameter int TIMEOUT_CYCLES  = 65536
) (
   input  wire logic         clock,
   input  wire logic         reset,
   solver_dispatch_if.master bus
);
   localparam int                  CNT_BITS   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONFIG = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESULT = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [LIMB_INDEX_BITS-1:0] r_job_limbs;
   logic [ITER_BITS-1:0]       r_job_iter;
   logic [LIMB_INDEX_BITS-1:0] r_nl_shadow;
   logic [ITER_BITS-1:0]       r_il_shadow;
   logic                       r_nl_valid;
   logic                       r_il_valid;
   logic [CNT_BITS-1:0]        r_wdog;
   logic [ITER_BITS-1:0]       r_res_iters;
   logic                       r_res_div;
   logic                       r_res_to;
   logic                       r_res_err;
   logic                       w_wdog_expired;

   assign w_wdog_expired      = (r_wdog == c_cnt_last);
   assign bus.result_iters    = r_res_iters;
   assign bus.result_diverged = r_res_div;
   assign bus.result_timeout  = r_res_to;
   assign bus.result_error    = r_res_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next        = r_state;
      bus.job_ready       = 1'b0;
      bus.wr_num_limbs_en = 1'b0;
      bus.wr_iter_lim_en  = 1'b0;
      bus.start           = 1'b0;
      bus.result_valid    = 1'b0;
      bus.busy            = 1'b1;
      // Outside CONFIG the shadows hold exactly the last data driven
      bus.num_limbs_data  = r_nl_shadow;
      bus.iter_lim_data   = r_il_shadow;
      case (r_state)
         ST_IDLE: begin
            bus.job_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.job_valid) begin
               w_state_next = (bus.job_num_limbs == '0) ? ST_RESULT : ST_CONFIG;
            end
         end
         ST_CONFIG: begin
            bus.num_limbs_data  = r_job_limbs;
            bus.iter_lim_data   = r_job_iter;
            bus.wr_num_limbs_en = !r_nl_valid || (r_nl_shadow != r_job_limbs);
            bus.wr_iter_lim_en  = !r_il_valid || (r_il_shadow != r_job_iter);
            w_state_next        = ST_START;
         end
         ST_START: begin
            bus.start    = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.solver_done || w_wdog_expired) begin
               w_state_next = ST_RESULT;
            end
         end
         ST_RESULT: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_job_limbs <= '0;
         r_job_iter  <= '0;
         r_nl_shadow <= '0;
         r_il_shadow <= '0;
         r_nl_valid  <= 1'b0;
         r_il_valid  <= 1'b0;
         r_wdog      <= '0;
         r_res_iters <= '0;
         r_res_div   <= 1'b0;
         r_res_to    <= 1'b0;
         r_res_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.job_valid) begin
                  r_job_limbs <= bus.job_num_limbs;
                  r_job_iter  <= bus.job_iter_lim;
                  if (bus.job_num_limbs == '0) begin
                     r_res_iters <= '0;
                     r_res_div   <= 1'b0;
                     r_res_to    <= 1'b0;
                     r_res_err   <= 1'b1;
                  end
               end
            end
            ST_CONFIG: begin
               r_nl_shadow <= r_job_limbs;
               r_il_shadow <= r_job_iter;
               r_nl_valid  <= 1'b1;
               r_il_valid  <= 1'b1;
            end
            ST_START: r_wdog <= '0;
            ST_WAIT: begin
               if (bus.solver_done) begin
                  r_res_iters <= bus.solver_iters;
                  r_res_div   <= bus.solver_diverged;
                  r_res_to    <= 1'b0;
                  r_res_err   <= 1'b0;
               end else if (w_wdog_expired) begin
                  // Solver state is unknown after a timeout: force both rewrites
                  r_res_iters <= '0;
                  r_res_div   <= 1'b0;
                  r_res_to    <= 1'b1;
                  r_res_err   <= 1'b0;
                  r_nl_valid  <= 1'b0;
                  r_il_valid  <= 1'b0;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
